// File: rtl/hex_display_sched.sv
// rtl/hex_display_sched.sv - round-robin scheduler sharing one TM1637 hex driver between requesters
module hex_display_sched #(
  parameter int NUM_SRC        = 2,
  parameter int DATA_W         = 16,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int BUSY_TIMEOUT   = 64
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_SRC-1:0]                                src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]                         src_data,
  output logic [NUM_SRC-1:0]                                src_done,
  output logic [DATA_W-1:0]                                 hex_data,
  output logic                                              hex_latch,
  input  logic                                              hex_busy,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0]  cur_src,
  output logic                                              timeout_err
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // Refresh fires when the idle counter reaches REFRESH_CYCLES-1; 0 disables it.
  localparam logic [31:0] REFRESH_LAST = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;
  // Busy-wait counter is preloaded with 1 in LATCH so the latch cycle counts toward the timeout.
  localparam logic [31:0] BUSY_LAST    = (BUSY_TIMEOUT > 1) ? 32'(BUSY_TIMEOUT - 1) : 32'd1;
  // Pointer starts at the last source so source 0 wins the first arbitration.
  localparam logic [SRC_W-1:0] RR_INIT = SRC_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, LATCH, WAIT_BUSY, XFER} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  slot_q [NUM_SRC];
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic               refresh_q;
  logic [31:0]        busy_cnt_q;
  logic [31:0]        refresh_cnt_q;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic               do_grant;
  logic               do_refresh;
  logic               busy_timeout;
  logic               xfer_end;

  // Round-robin pick: first pending source after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state and single-cycle controls; pending requests take priority over refresh.
  always_comb begin
    state_d      = state_q;
    do_grant     = 1'b0;
    do_refresh   = 1'b0;
    busy_timeout = 1'b0;
    xfer_end     = 1'b0;
    hex_latch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hex_busy) begin
          if (grant_found) begin
            do_grant = 1'b1;
            state_d  = LATCH;
          end else if (REFRESH_CYCLES != 0 && refresh_cnt_q == REFRESH_LAST) begin
            do_refresh = 1'b1;
            state_d    = LATCH;
          end
        end
      end
      LATCH: begin
        hex_latch = 1'b1;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (hex_busy) begin
          state_d = XFER;
        end else if (busy_cnt_q >= BUSY_LAST) begin
          busy_timeout = 1'b1;
          state_d      = IDLE;
        end
      end
      XFER: begin
        if (!hex_busy) begin
          xfer_end = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending flags: new writes set, a grant clears unless the same source rewrites that cycle.
  always_comb begin
    pend_d = pend_q | src_valid;
    if (do_grant && !src_valid[grant_idx]) begin
      pend_d[grant_idx] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-source slots capture the latest value; writes are always accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i]) begin
          slot_q[i] <= src_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Send datapath: shown value, owner, pointer, refresh marker and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_data    <= '0;
      cur_src     <= '0;
      rr_ptr_q    <= RR_INIT;
      refresh_q   <= 1'b0;
      src_done    <= '0;
      timeout_err <= 1'b0;
    end else begin
      src_done    <= '0;
      timeout_err <= busy_timeout;
      if (xfer_end && !refresh_q) begin
        src_done[cur_src] <= 1'b1;
      end
      if (do_grant) begin
        hex_data  <= slot_q[grant_idx];
        cur_src   <= grant_idx;
        rr_ptr_q  <= grant_idx;
        refresh_q <= 1'b0;
      end else if (do_refresh) begin
        refresh_q <= 1'b1;
      end
    end
  end

  // Busy-wait timer and idle refresh timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q    <= '0;
      refresh_cnt_q <= '0;
    end else begin
      if (state_q == LATCH) begin
        busy_cnt_q <= 32'd1;
      end else if (state_q == WAIT_BUSY) begin
        busy_cnt_q <= busy_cnt_q + 32'd1;
      end
      if (state_q == LATCH || xfer_end) begin
        refresh_cnt_q <= '0;
      end else if (state_q == IDLE && refresh_cnt_q != REFRESH_LAST) begin
        refresh_cnt_q <= refresh_cnt_q + 32'd1;
      end
    end
  end

endmodule
